// File: rtl/data_ram_resp_pkg.sv
// Shared widths, defaults and FSM encoding for the data-memory responder.
package data_ram_resp_pkg;

  localparam int REG_BUS           = 32;
  localparam int DATA_MEM_NUM_LOG2 = 12;
  localparam int CNT_W             = 4;

  typedef enum logic [1:0] {
    DR_IDLE = 2'd0,
    DR_WAIT = 2'd1,
    DR_DONE = 2'd2
  } dr_state_e;

endpackage

// File: rtl/data_ram_resp_dmem_array.sv
// Word-organised data array: one 8-bit synchronous RAM per byte lane,
// independent lane write enables, registered read port.
module dmem_array #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [0:(1<<ADDR_W)-1];
    logic [7:0] rd_q;

    // NOTE: no reset on the storage or read port so the lane maps onto block RAM.
    always_ff @(posedge clk) begin
      if (we[l]) mem[waddr] <= wdata[8*l +: 8];
      rd_q <= mem[raddr];
    end

    assign rdata[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/data_ram_resp.sv
// Memory side of the core's load/store port: single-cycle stores, multi-cycle
// loads that hold the pipeline via stallreq_o until the read word is valid.
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int ADDR_W      = DATA_MEM_NUM_LOG2,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_ce_i,
  input  logic               mem_we_i,
  input  logic [REG_BUS-1:0] mem_addr_i,
  input  logic [3:0]         mem_sel_i,
  input  logic [REG_BUS-1:0] mem_data_i,
  output logic [REG_BUS-1:0] mem_data_o,
  output logic               stallreq_o,
  output logic               err_o
);

  dr_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  idx_q;
  logic               oor_q;
  logic [REG_BUS-1:0] rdata_q;
  logic               err_q;

  logic [ADDR_W-1:0]  word_idx;
  logic               oor;
  logic [ADDR_W-1:0]  raddr;
  logic [REG_BUS-1:0] arr_rdata;
  logic [3:0]         lane_we;
  logic               load_go;
  logic               capture;
  logic               store_err;
  logic               unused_addr_lsb;

  assign word_idx        = mem_addr_i[ADDR_W+1:2];
  assign oor             = |mem_addr_i[REG_BUS-1:ADDR_W+2];
  assign unused_addr_lsb = ^mem_addr_i[1:0];

  // In IDLE the array reads the incoming address, so with zero wait states the
  // word is already in the array's output register when WAIT needs it.
  assign raddr = (state_q == DR_IDLE) ? word_idx : idx_q;

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (lane_we),
    .waddr (word_idx),
    .wdata (mem_data_i),
    .raddr (raddr),
    .rdata (arr_rdata)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches.
    state_d    = state_q;
    cnt_d      = cnt_q;
    stallreq_o = 1'b0;
    lane_we    = 4'b0000;
    load_go    = 1'b0;
    capture    = 1'b0;
    store_err  = 1'b0;
    unique case (state_q)
      DR_IDLE: begin
        // Gated with rst so a held load request cannot stall a core in reset.
        if (mem_ce_i && rst) begin
          if (mem_we_i) begin
            if (oor) store_err = 1'b1;
            else     lane_we   = mem_sel_i;
          end else begin
            stallreq_o = 1'b1;
            load_go    = 1'b1;
            cnt_d      = CNT_W'(WAIT_CYCLES);
            state_d    = DR_WAIT;
          end
        end
      end
      DR_WAIT: begin
        stallreq_o = 1'b1;
        if (!mem_ce_i) begin
          state_d = DR_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          capture = 1'b1;
          state_d = DR_DONE;
        end
      end
      DR_DONE: state_d = DR_IDLE;
      default: state_d = DR_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DR_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_go) begin
        idx_q <= word_idx;
        oor_q <= oor;
      end
      if (capture) rdata_q <= oor_q ? '0 : arr_rdata;
      if (store_err || (capture && oor_q)) err_q <= 1'b1;
    end
  end

  assign mem_data_o = rdata_q;
  assign err_o      = err_q;

endmodule
